// File: rtl/lcd_glyph_fetch_if.sv
// Memory-side bus of the glyph fetcher: text RAM lookup and font ROM read.
// Both memories return data one cycle after their address register updates.
interface lcd_glyph_fetch_if;
    logic [3:0]  txt_addr;
    logic [7:0]  txt_data;
    logic        rom_rd_en;
    logic [12:0] rom_addr;
    logic [31:0] rom_data;

    modport master (output txt_addr, rom_rd_en, rom_addr, input txt_data, rom_data);
    modport slave  (input txt_addr, rom_rd_en, rom_addr, output txt_data, rom_data);
endinterface

// File: rtl/lcd_glyph_fetch.sv
// Per-line glyph row scheduler: on each new in-band line, fetch one font row
// per character (text RAM -> font ROM) and commit them to line_bits.
module lcd_glyph_fetch #(
    parameter logic [10:0] POS_X    = 11'd336,
    parameter logic [10:0] POS_Y    = 11'd224,
    parameter logic [10:0] HEIGHT   = 11'd32,
    parameter int          CHAR_NUM = 4
) (
    input  logic                    lcd_clk,
    input  logic                    sys_rst,
    input  logic [10:0]             pixel_xpos,
    input  logic [10:0]             pixel_ypos,
    lcd_glyph_fetch_if.master       mem,
    output logic [32*CHAR_NUM-1:0]  line_bits,
    output logic                    line_valid,
    output logic                    underrun,
    input  logic                    underrun_clr
);
    localparam int       LW   = 32*CHAR_NUM;
    localparam bit [3:0] LAST = 4'(CHAR_NUM-1);

    typedef enum logic [2:0] {IDLE, TXT, ROM, CAP, COMMIT} state_t;

    state_t         state, state_n;
    logic [10:0]    y_prev;
    logic [4:0]     row, row_n;
    logic [3:0]     idx, idx_n;
    logic [LW-1:0]  shadow, shadow_n, line_bits_n;
    logic           line_valid_n, underrun_n, ur_set;
    logic [3:0]     txt_addr_n;
    logic [12:0]    rom_addr_n;
    logic           rom_rd_en_n;
    logic           line_start, in_band;

    assign line_start = (pixel_ypos != y_prev);
    // 12-bit compare so POS_Y+HEIGHT cannot wrap past 2047
    assign in_band = (pixel_ypos >= POS_Y) &&
                     ({1'b0, pixel_ypos} < ({1'b0, POS_Y} + {1'b0, HEIGHT}));

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        row_n        = row;
        shadow_n     = shadow;
        line_bits_n  = line_bits;
        line_valid_n = line_valid;
        txt_addr_n   = mem.txt_addr;
        rom_addr_n   = mem.rom_addr;
        rom_rd_en_n  = 1'b0;
        ur_set       = 1'b0;

        if (line_start) begin
            // A new line mid-fetch is an underrun, but still restarts the fetch
            ur_set       = (state != IDLE);
            line_valid_n = 1'b0;
            if (in_band) begin
                row_n    = 5'(pixel_ypos - POS_Y);
                idx_n    = 4'd0;
                shadow_n = '0;
                state_n  = TXT;
            end else begin
                state_n  = IDLE;
            end
        end else if (state != IDLE && pixel_xpos >= POS_X) begin
            ur_set       = 1'b1;
            line_valid_n = 1'b0;
            state_n      = IDLE;
        end else begin
            unique case (state)
                TXT: begin
                    txt_addr_n = idx;
                    state_n    = ROM;
                end
                ROM: begin
                    rom_addr_n  = {mem.txt_data, row};
                    rom_rd_en_n = 1'b1;
                    state_n     = CAP;
                end
                CAP: begin
                    shadow_n = LW'({shadow, mem.rom_data});
                    if (idx == LAST) begin
                        state_n = COMMIT;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = TXT;
                    end
                end
                COMMIT: begin
                    line_bits_n  = shadow;
                    line_valid_n = 1'b1;
                    state_n      = IDLE;
                end
                default: ;
            endcase
        end

        underrun_n = ur_set | (underrun & ~underrun_clr);
    end

    always_ff @(posedge lcd_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            y_prev        <= '0;
            row           <= '0;
            idx           <= '0;
            shadow        <= '0;
            line_bits     <= '0;
            line_valid    <= 1'b0;
            underrun      <= 1'b0;
            mem.txt_addr  <= '0;
            mem.rom_addr  <= '0;
            mem.rom_rd_en <= 1'b0;
        end else begin
            state         <= state_n;
            y_prev        <= pixel_ypos;
            row           <= row_n;
            idx           <= idx_n;
            shadow        <= shadow_n;
            line_bits     <= line_bits_n;
            line_valid    <= line_valid_n;
            underrun      <= underrun_n;
            mem.txt_addr  <= txt_addr_n;
            mem.rom_addr  <= rom_addr_n;
            mem.rom_rd_en <= rom_rd_en_n;
        end
    end
endmodule

// File: tb/tb_lcd_glyph_fetch.sv
// Directed bench for lcd_glyph_fetch with text RAM and font ROM models.
module tb_lcd_glyph_fetch;
    logic          lcd_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [10:0]   pixel_xpos = '0;
    logic [10:0]   pixel_ypos = '0;
    logic          underrun_clr = 1'b0;
    logic [127:0]  line_bits;
    logic          line_valid, underrun;

    int            total = 0;
    int            bad = 0;
    int            consec = 0;
    logic          prev_rd = 1'b0;
    logic [12:0]   rq[$];
    logic [7:0]    txt_ram [16];

    lcd_glyph_fetch_if bus();

    lcd_glyph_fetch dut (
        .lcd_clk      (lcd_clk),
        .sys_rst      (sys_rst),
        .pixel_xpos   (pixel_xpos),
        .pixel_ypos   (pixel_ypos),
        .mem          (bus),
        .line_bits    (line_bits),
        .line_valid   (line_valid),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 lcd_clk = ~lcd_clk;

    function automatic logic [31:0] font(input logic [12:0] a);
        return {a, 6'h2A, a};
    endfunction

    function automatic logic [127:0] exp_line(input logic [4:0] r);
        return {font({8'h10, r}), font({8'h11, r}), font({8'h12, r}), font({8'h13, r})};
    endfunction

    assign bus.txt_data = txt_ram[bus.txt_addr];
    assign bus.rom_data = bus.rom_rd_en ? font(bus.rom_addr) : 32'h0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge lcd_clk);
        #1;
        if (bus.rom_rd_en) begin
            if (prev_rd) consec++;
            rq.push_back(bus.rom_addr);
        end
        prev_rd = bus.rom_rd_en;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ypos change, then line_valid must rise exactly 14 cycles later
    task automatic run_line(input logic [10:0] y, input logic [4:0] r, input string tag);
        rq.delete();
        pixel_ypos = y;
        ticks(13);
        chk({tag, "_lv_early"}, line_valid, 1'b0);
        tick();
        chk({tag, "_lv"}, line_valid, 1'b1);
        chk({tag, "_bits"}, line_bits, exp_line(r));
        chk({tag, "_nrd"}, rq.size(), 4);
        if (rq.size() == 4) begin
            chk({tag, "_a0"}, rq[0], {8'h10, r});
            chk({tag, "_a3"}, rq[3], {8'h13, r});
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) txt_ram[i] = 8'h10 + 8'(i);

        ticks(3);
        chk("rst_bits", line_bits, 128'h0);
        chk("rst_lv", line_valid, 1'b0);
        chk("rst_ur", underrun, 1'b0);
        chk("rst_txt", bus.txt_addr, 4'h0);
        chk("rst_rom", bus.rom_addr, 13'h0);
        chk("rst_rd", bus.rom_rd_en, 1'b0);
        sys_rst = 1'b0;

        // first in-band line from 223
        pixel_ypos = 11'd223;
        rq.delete();
        ticks(4);
        chk("y223_nrd", rq.size(), 0);
        run_line(11'd224, 5'd0, "y224");
        if (rq.size() == 4) begin
            chk("y224_a1", rq[1], 13'h220);
            chk("y224_a2", rq[2], 13'h240);
        end
        chk("y224_a0_lit", rq[0], 13'h200);
        chk("y224_ur", underrun, 1'b0);

        for (int y = 225; y < 256; y++)
            run_line(11'(y), 5'(y - 224), $sformatf("sweep%0d", y));

        // leaving the band
        rq.delete();
        pixel_ypos = 11'd256;
        tick();
        chk("y256_lv", line_valid, 1'b0);
        ticks(20);
        chk("y256_nrd", rq.size(), 0);
        chk("y256_bits", line_bits, exp_line(5'd31));

        // deadline abort at cycle 5
        pixel_ypos = 11'd224;
        ticks(5);
        pixel_xpos = 11'd336;
        tick();
        pixel_xpos = 11'd0;
        chk("dl_ur", underrun, 1'b1);
        chk("dl_lv", line_valid, 1'b0);
        chk("dl_bits", line_bits, exp_line(5'd31));
        rq.delete();
        ticks(20);
        chk("dl_idle_nrd", rq.size(), 0);
        chk("dl_idle_lv", line_valid, 1'b0);
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("dl_clr", underrun, 1'b0);

        // new-line abort at cycle 6, clear requested in the same cycle
        pixel_ypos = 11'd225;
        ticks(6);
        pixel_ypos = 11'd226;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("nl_ur_set_wins", underrun, 1'b1);
        rq.delete();
        ticks(12);
        chk("nl_lv_early", line_valid, 1'b0);
        tick();
        chk("nl_lv", line_valid, 1'b1);
        chk("nl_bits", line_bits, exp_line(5'd2));
        chk("nl_nrd", rq.size(), 4);
        chk("nl_a0", rq[0], 13'h202);

        // reset during CAP
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        chk("pre_rst_ur", underrun, 1'b0);
        pixel_ypos = 11'd227;
        ticks(3);
        chk("cap_rd", bus.rom_rd_en, 1'b1);
        sys_rst = 1'b1;
        tick();
        chk("mrst_bits", line_bits, 128'h0);
        chk("mrst_lv", line_valid, 1'b0);
        chk("mrst_ur", underrun, 1'b0);
        chk("mrst_txt", bus.txt_addr, 4'h0);
        chk("mrst_rom", bus.rom_addr, 13'h0);
        chk("mrst_rd", bus.rom_rd_en, 1'b0);
        sys_rst = 1'b0;
        rq.delete();
        ticks(13);
        chk("post_rst_lv_early", line_valid, 1'b0);
        tick();
        chk("post_rst_lv", line_valid, 1'b1);
        chk("post_rst_bits", line_bits, exp_line(5'd3));
        chk("post_rst_ur", underrun, 1'b0);
        chk("post_rst_nrd", rq.size(), 4);

        // out-of-band line changes
        rq.delete();
        pixel_ypos = 11'd0;
        tick();
        chk("oob_lv", line_valid, 1'b0);
        ticks(3);
        pixel_ypos = 11'd1;
        ticks(4);
        pixel_ypos = 11'd479;
        ticks(4);
        pixel_ypos = 11'd0;
        ticks(20);
        chk("oob_nrd", rq.size(), 0);
        chk("oob_txt", bus.txt_addr, 4'h3);
        chk("oob_lv_end", line_valid, 1'b0);
        chk("oob_ur", underrun, 1'b0);

        chk("no_back2back", consec, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lcd_glyph_fetch.md
# lcd_glyph_fetch

Per-line glyph row scheduler for the RGB LCD character overlay. On every new display line inside the character band, it fetches one 32-bit glyph row per character: first the character code from the text RAM, then the row from the 32×32 font ROM. It packs the rows into a line register that the pixel colouring stage indexes as `line_bits[32*CHAR_NUM-1 - x_cnt]`. This replaces hard-coded glyph arrays and makes the font ROM the single shared resource, accessed only by this block.

## Interface
Parameters:
- POS_X, 11'd336, first pixel column of the character band
- POS_Y, 11'd224, first pixel row of the character band
- HEIGHT, 11'd32, band height in lines (glyph height)
- CHAR_NUM, 4, characters per line (1..16); band width = 32*CHAR_NUM

Ports (one clock; reset is synchronous and active-high):
- lcd_clk  in  1  LCD pixel clock; all logic on rising edge
- sys_rst  in  1  synchronous active-high reset
- pixel_xpos  in  11  current pixel column from LCD driver
- pixel_ypos  in  11  current pixel row from LCD driver
- txt_addr  out  4  text RAM address (character index)
- txt_data  in  8  character code; valid 1 cycle after txt_addr
- rom_rd_en  out  1  font ROM read strobe
- rom_addr  out  13  {char_code[7:0], row[4:0]}
- rom_data  in  32  glyph row, MSB = leftmost pixel; valid 1 cycle after rom_rd_en
- line_bits  out  32*CHAR_NUM  committed glyph row for current line; char 0 in MSBs
- line_valid  out  1  line_bits belongs to current pixel_ypos
- underrun  out  1  sticky: a fetch failed to commit before pixel_xpos reached POS_X
- underrun_clr  in  1  clears underrun

## Operation
- Line detect: register y_prev <= pixel_ypos every cycle. line_start = (pixel_ypos != y_prev).
- In-band: POS_Y <= pixel_ypos < POS_Y+HEIGHT. row = (pixel_ypos - POS_Y)[4:0].
- FSM states: IDLE, TXT, ROM, CAP, COMMIT.
- IDLE: on line_start, line_valid <= 0.
  - If in-band: latch row, idx <= 0, shadow <= 0, go to TXT.
  - Otherwise stay in IDLE.
- TXT: txt_addr <= idx, then go to ROM.
- ROM: rom_addr <= {txt_data, row}, rom_rd_en <= 1 for exactly this one cycle, then go to CAP.
- CAP: shadow <= {shadow[32*CHAR_NUM-33:0], rom_data}.
  - If idx == CHAR_NUM-1, go to COMMIT.
  - Otherwise idx <= idx+1 and go to TXT.
- COMMIT: line_bits <= shadow, line_valid <= 1, then go to IDLE.
- Abort on new line: line_start in any non-IDLE state sets underrun <= 1 and restarts the fetch as IDLE would (including the in-band check). line_bits is not updated.
- Abort on deadline: in any non-IDLE state, if pixel_xpos >= POS_X on a cycle without line_start, set underrun <= 1 and return to IDLE with line_valid = 0. line_bits keeps its old value.
- underrun_clr clears underrun. If a set and a clear occur in the same cycle, set wins.
- Out-of-band lines leave line_valid = 0. The downstream stage must draw background colour whenever line_valid = 0.
- Widths: row uses 5 bits. txt_addr zero-extends idx to 4 bits. The band arithmetic is 11-bit unsigned; the band-end comparisons must not wrap.

## Timing
- Reset values: state IDLE; line_bits 0; line_valid 0; underrun 0; txt_addr 0; rom_addr 0; rom_rd_en 0; y_prev 0; idx 0.
- Fetch latency: line_start is seen in cycle 0. TXT runs in cycle 1. COMMIT runs in cycle 3*CHAR_NUM+1. line_valid is high from cycle 3*CHAR_NUM+2, which is cycle 14 for CHAR_NUM = 4.
- Deadline: POS_X must be greater than 3*CHAR_NUM+2 cycles after line_start. With the defaults there are 336 cycles available.
- Exactly CHAR_NUM rom_rd_en pulses per completed fetch, never on consecutive cycles.
- Reset asserted mid-fetch: the next cycle is IDLE with all outputs at their reset values. No partial commit.

## Test plan
- Reset, then pixel_ypos steps 223 → 224 with text RAM = {0x10, 0x11, 0x12, 0x13} -> rom_addr sequence 0x200, 0x220, 0x240, 0x260. line_valid rises 14 cycles after the ypos change. line_bits = {rom rows} with char 0 in bits [127:96].
- Sweep ypos 224..255, then 256 -> every in-band line commits with row = ypos-224; at ypos 256, line_valid drops on the line_start cycle and there are no ROM reads.
- Force pixel_xpos = 336 at cycle 5 of a fetch -> underrun = 1, line_valid stays 0, FSM in IDLE, line_bits unchanged. underrun_clr then clears it.
- Change ypos again at cycle 6 of a fetch (225 → 226) -> underrun = 1, new fetch uses row 2 and commits 14 cycles later.
- Assert sys_rst during CAP -> next cycle all outputs 0, no commit. The next in-band line_start fetches normally.
- ypos stepping outside the band (0 → 1, 479 → 0) -> no txt or ROM activity, line_valid = 0.
